traffic_control_unit: RTL and testbench

TRAFFIC_CONTROL_UNIT -- requirements
Module: traffic_control_unit

---
 rtl/traffic_control_unit.sv | 127 ++++++++++++
 tb/tb_traffic_control_unit.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_control_unit.sv
// traffic_control_unit
//   Control FSM for a four-way signalised junction. Sequences north/south and
//   east/west green phases separated by all-red clearance phases. Phase length
//   is counted in Count_Flag pulses from an external datapath timer. A latched
//   pedestrian request can cut a green phase short once a minimum has been
//   served. An emergency input forces every lamp to red.
//
// Parameters
//   GREEN_TICKS  Count_Flag pulses per green phase (1..15)
//   CLEAR_TICKS  Count_Flag pulses per all-red / clearance phase (1..15)
//   MIN_TICKS    minimum green pulses before a pedestrian request ends green
//
// Ports
//   CU_CLK      clock, rising edge
//   CU_Rst      asynchronous active-high reset
//   Count_Flag  one-cycle timer expiry pulse
//   Ped_Req     pedestrian request (level)
//   Emergency   emergency override (level)
//   CU_North/CU_South/CU_East/CU_West  lamp select, 1 = green
//   Count_Clr   one-cycle pulse in the cycle after each state change
//   CU_State    current state code, for debug
module traffic_control_unit #(
    parameter int unsigned GREEN_TICKS = 4,
    parameter int unsigned CLEAR_TICKS = 1,
    parameter int unsigned MIN_TICKS   = 2
) (
    input  logic       CU_CLK,
    input  logic       CU_Rst,
    input  logic       Count_Flag,
    input  logic       Ped_Req,
    input  logic       Emergency,
    output logic       CU_North,
    output logic       CU_South,
    output logic       CU_East,
    output logic       CU_West,
    output logic       Count_Clr,
    output logic [2:0] CU_State
);

    typedef enum logic [2:0] {
        StAllRed  = 3'd0,
        StNsGreen = 3'd1,
        StNsClear = 3'd2,
        StEwGreen = 3'd3,
        StEwClear = 3'd4,
        StEmerg   = 3'd5
    } state_e;

    localparam logic [3:0] GreenLast = 4'(GREEN_TICKS - 1);
    localparam logic [3:0] ClearLast = 4'(CLEAR_TICKS - 1);
    localparam logic [3:0] MinLast   = 4'(MIN_TICKS - 1);

    state_e     state_q, state_d;
    logic [3:0] tick_q, tick_d;
    logic       ped_q, ped_d;
    logic       count_clr_q;

    logic is_green;
    logic phase_done;
    logic ped_done;
    logic advance;
    logic changed;

    always_comb begin
        is_green   = (state_q == StNsGreen) || (state_q == StEwGreen);
        phase_done = Count_Flag && (tick_q == (is_green ? GreenLast : ClearLast));
        // Pedestrian early exit uses the latched request, so a request seen
        // in this cycle first takes effect on the next Count_Flag.
        ped_done   = is_green && ped_q && Count_Flag && (tick_q >= MinLast);
        advance    = phase_done || ped_done;

        state_d = state_q;
        if (Emergency) begin
            state_d = StEmerg;
        end else begin
            case (state_q)
                StAllRed:  if (advance) state_d = StNsGreen;
                StNsGreen: if (advance) state_d = StNsClear;
                StNsClear: if (advance) state_d = StEwGreen;
                StEwGreen: if (advance) state_d = StEwClear;
                StEwClear: if (advance) state_d = StNsGreen;
                StEmerg:   state_d = StAllRed;
                default:   state_d = StAllRed;
            endcase
        end

        changed = (state_d != state_q);

        tick_d = tick_q;
        if (changed) begin
            tick_d = 4'd0;
        end else if (Count_Flag) begin
            tick_d = tick_q + 4'd1;
        end

        // Leaving green consumes the request; otherwise requests accumulate
        // so one raised during clearance applies to the next green.
        ped_d = ped_q | Ped_Req;
        if (is_green && changed) begin
            ped_d = 1'b0;
        end
    end

    always_ff @(posedge CU_CLK or posedge CU_Rst) begin
        if (CU_Rst) begin
            state_q     <= StAllRed;
            tick_q      <= 4'd0;
            ped_q       <= 1'b0;
            count_clr_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_q      <= tick_d;
            ped_q       <= ped_d;
            count_clr_q <= changed;
        end
    end

    always_comb begin
        CU_North  = (state_q == StNsGreen);
        CU_South  = (state_q == StNsGreen);
        CU_East   = (state_q == StEwGreen);
        CU_West   = (state_q == StEwGreen);
        Count_Clr = count_clr_q;
        CU_State  = state_q;
    end

endmodule

// File: tb/tb_traffic_control_unit.sv
module tb_traffic_control_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flag = 1'b0;
    logic       ped = 1'b0;
    logic       emerg = 1'b0;
    logic       north, south, east, west;
    logic       clr;
    logic [2:0] st;

    int n_checks = 0;
    int n_fail   = 0;
    logic [2:0] prev_state = 3'd0;

    always #5 clk = ~clk;

    traffic_control_unit #(
        .GREEN_TICKS(4),
        .CLEAR_TICKS(1),
        .MIN_TICKS  (2)
    ) dut (
        .CU_CLK    (clk),
        .CU_Rst    (rst),
        .Count_Flag(flag),
        .Ped_Req   (ped),
        .Emergency (emerg),
        .CU_North  (north),
        .CU_South  (south),
        .CU_East   (east),
        .CU_West   (west),
        .Count_Clr (clr),
        .CU_State  (st)
    );

    // Advance one clock, sample 1 time unit after the edge and check the
    // safety invariants that must hold in every cycle.
    task automatic step();
        @(posedge clk);
        #1;
        n_checks += 3;
        if (((north | south) & (east | west)) !== 1'b0) begin
            n_fail++;
            $display("FAIL overlap: NS=%b%b EW=%b%b, required no overlap",
                     north, south, east, west);
        end
        if ({north, south, east, west} !== {st == 3'd1, st == 3'd1, st == 3'd3, st == 3'd3}) begin
            n_fail++;
            $display("FAIL lamp_decode: lamps=%b in state %0d", {north, south, east, west}, st);
        end
        if ((st == 3'd1 || st == 3'd3) && st != prev_state &&
            !(prev_state == 3'd0 || prev_state == 3'd2 || prev_state == 3'd4)) begin
            n_fail++;
            $display("FAIL green_entry: entered %0d from %0d, required clear/allred before",
                     st, prev_state);
        end
        prev_state = st;
    endtask

    task automatic test_reset();
        #2;
        n_checks += 2;
        if (st !== 3'd0 || clr !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: state=%0d clr=%b, required 0/0", st, clr);
        end
        if ({north, south, east, west} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_lamps: got %b required 0000", {north, south, east, west});
        end
        flag = 1'b1;
        step();
        step();
        n_checks++;
        if (st !== 3'd0 || clr !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold: state=%0d clr=%b, required 0/0", st, clr);
        end
        flag = 1'b0;
        rst  = 1'b0;
        step();
    endtask

    task automatic test_normal();
        logic [2:0] exp_st  [11] = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3,
                                     3'd4, 3'd1};
        logic       exp_clr [11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
                                     1'b1, 1'b1};
        for (int i = 0; i < 11; i++) begin
            flag = 1'b1;
            step();
            flag = 1'b0;
            n_checks += 3;
            if (st !== exp_st[i]) begin
                n_fail++;
                $display("FAIL normal_state[%0d]: got %0d required %0d", i, st, exp_st[i]);
            end
            if (clr !== exp_clr[i]) begin
                n_fail++;
                $display("FAIL normal_clr[%0d]: got %b required %b", i, clr, exp_clr[i]);
            end
            if ({north, east} !== {exp_st[i] == 3'd1, exp_st[i] == 3'd3}) begin
                n_fail++;
                $display("FAIL normal_lamps[%0d]: N=%b E=%b in expected state %0d",
                         i, north, east, exp_st[i]);
            end
            step();
            n_checks++;
            if (clr !== 1'b0) begin
                n_fail++;
                $display("FAIL normal_clr_width[%0d]: got %b required 0", i, clr);
            end
            step();
            step();
        end
    endtask

    // Starts in NS_GREEN tick 0.
    task automatic test_ped_green();
        logic [2:0] exp_st  [7] = '{3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd4};
        logic       exp_clr [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        ped = 1'b1;
        step();
        ped = 1'b0;
        n_checks++;
        if (st !== 3'd1) begin
            n_fail++;
            $display("FAIL ped_hold: got %0d required 1", st);
        end
        for (int i = 0; i < 7; i++) begin
            flag = 1'b1;
            step();
            flag = 1'b0;
            n_checks += 2;
            if (st !== exp_st[i]) begin
                n_fail++;
                $display("FAIL ped_state[%0d]: got %0d required %0d", i, st, exp_st[i]);
            end
            if (clr !== exp_clr[i]) begin
                n_fail++;
                $display("FAIL ped_clr[%0d]: got %b required %b", i, clr, exp_clr[i]);
            end
            step();
            step();
            step();
        end
    endtask

    // Starts in EW_CLEAR tick 0.
    task automatic test_ped_clear();
        logic [2:0] exp_a [5] = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd2};
        logic [2:0] exp_b [4] = '{3'd3, 3'd3, 3'd4, 3'd1};
        for (int i = 0; i < 5; i++) begin
            flag = 1'b1;
            step();
            flag = 1'b0;
            n_checks++;
            if (st !== exp_a[i]) begin
                n_fail++;
                $display("FAIL pedclr_lead[%0d]: got %0d required %0d", i, st, exp_a[i]);
            end
            step();
        end
        ped = 1'b1;
        step();
        ped = 1'b0;
        for (int i = 0; i < 4; i++) begin
            flag = 1'b1;
            step();
            flag = 1'b0;
            n_checks++;
            if (st !== exp_b[i]) begin
                n_fail++;
                $display("FAIL pedclr_state[%0d]: got %0d required %0d", i, st, exp_b[i]);
            end
            step();
            step();
        end
    endtask

    // Starts in NS_GREEN tick 0.
    task automatic test_emergency();
        logic [2:0] exp_st [8] = '{3'd1, 3'd1, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3};
        for (int i = 0; i < 8; i++) begin
            flag = 1'b1;
            step();
            flag = 1'b0;
            n_checks++;
            if (st !== exp_st[i]) begin
                n_fail++;
                $display("FAIL emerg_lead[%0d]: got %0d required %0d", i, st, exp_st[i]);
            end
            step();
        end
        // EW_GREEN at tick 3: Count_Flag alone would end the phase.
        emerg = 1'b1;
        flag  = 1'b1;
        step();
        flag = 1'b0;
        n_checks += 2;
        if (st !== 3'd5 || clr !== 1'b1) begin
            n_fail++;
            $display("FAIL emerg_enter: state=%0d clr=%b, required 5/1", st, clr);
        end
        if ({north, south, east, west} !== 4'b0000) begin
            n_fail++;
            $display("FAIL emerg_lamps: got %b required 0000", {north, south, east, west});
        end
        flag = 1'b1;
        step();
        flag = 1'b0;
        step();
        n_checks++;
        if (st !== 3'd5 || clr !== 1'b0) begin
            n_fail++;
            $display("FAIL emerg_hold: state=%0d clr=%b, required 5/0", st, clr);
        end
        emerg = 1'b0;
        step();
        n_checks++;
        if (st !== 3'd0 || clr !== 1'b1) begin
            n_fail++;
            $display("FAIL emerg_exit: state=%0d clr=%b, required 0/1", st, clr);
        end
        step();
        flag = 1'b1;
        step();
        flag = 1'b0;
        n_checks++;
        if (st !== 3'd1 || clr !== 1'b1) begin
            n_fail++;
            $display("FAIL emerg_resume: state=%0d clr=%b, required 1/1", st, clr);
        end
        step();
    endtask

    // Starts in NS_GREEN tick 0: three state changes on consecutive edges.
    task automatic test_back_to_back();
        logic [2:0] exp_st [4] = '{3'd5, 3'd0, 3'd1, 3'd1};
        logic       exp_clr [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        emerg = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            emerg = 1'b0;
            flag  = (i == 1);
            n_checks++;
            if (st !== exp_st[i] || clr !== exp_clr[i]) begin
                n_fail++;
                $display("FAIL b2b[%0d]: state=%0d clr=%b, required %0d/%b",
                         i, st, clr, exp_st[i], exp_clr[i]);
            end
        end
        flag = 1'b0;
    endtask

    // Starts in NS_GREEN tick 0.
    task automatic test_reset_mid();
        for (int i = 0; i < 2; i++) begin
            flag = 1'b1;
            step();
            flag = 1'b0;
            step();
        end
        n_checks++;
        if (st !== 3'd1) begin
            n_fail++;
            $display("FAIL rstmid_pre: got %0d required 1", st);
        end
        #3;
        rst = 1'b1;
        #1;
        n_checks += 2;
        if (st !== 3'd0 || clr !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_async: state=%0d clr=%b, required 0/0", st, clr);
        end
        if ({north, south, east, west} !== 4'b0000) begin
            n_fail++;
            $display("FAIL rstmid_lamps: got %b required 0000", {north, south, east, west});
        end
        flag = 1'b1;
        step();
        flag = 1'b0;
        n_checks++;
        if (st !== 3'd0 || clr !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_hold: state=%0d clr=%b, required 0/0", st, clr);
        end
        rst = 1'b0;
        step();
        // Full green from tick 0: three pulses hold, the fourth ends it.
        for (int i = 0; i < 5; i++) begin
            flag = 1'b1;
            step();
            flag = 1'b0;
            n_checks++;
            if (st !== ((i == 4) ? 3'd2 : 3'd1)) begin
                n_fail++;
                $display("FAIL rstmid_resume[%0d]: got %0d required %0d",
                         i, st, (i == 4) ? 2 : 1);
            end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_ped_green();
        test_ped_clear();
        test_emergency();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
